board_gen: RTL

//  Upstream of game_logic: builds a shuffled board of matching pairs into a packed board image.
//  It drives game_logic's vid_mem load and its finishedGen input.

---
 rtl/board_gen_pkg.sv | 22 ++
 rtl/board_gen_if.sv | 31 +++
 rtl/board_gen_lfsr16.sv | 33 +++
 rtl/board_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/board_gen_pkg.sv
// Shared board-geometry constants, symbol/LFSR constants and the LFSR step helper.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package board_gen_pkg;

  // Board geometry shared with game_logic and the VGA path.
  localparam int BITS_PER_BLOCK = 4;
  localparam int BLOCKS_WIDE    = 4;
  localparam int BLOCKS_HIGH    = 3;

  // Symbol 0 marks an empty or already-matched block; pairs use 1..N/2.
  localparam logic [BITS_PER_BLOCK-1:0] SYM_EMPTY = '0;

  // Galois feedback taps for the 16-bit LFSR (maximal length).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One Galois step: shift right, fold the bit shifted out back in through the taps.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/board_gen_if.sv
// Board-build request/result bundle between board_gen and its consumer (game_logic).
// Latency: wires only.
// Backpressure: none; start is a one-cycle request, done is a level.
interface board_gen_if
  import board_gen_pkg::*;
#(
  parameter int BOARD_W = BITS_PER_BLOCK * BLOCKS_WIDE * BLOCKS_HIGH
);

  logic               start;  // one-cycle build request
  logic [BOARD_W-1:0] board;  // packed board image, block k at [k*BITS +: BITS]
  logic               busy;   // filling or shuffling
  logic               done;   // board valid and stable

  // The generator side.
  modport master (
    input  start,
    output board,
    output busy,
    output done
  );

  // The consumer side (game_logic / bench).
  modport slave (
    output start,
    input  board,
    input  busy,
    input  done
  );

endinterface

// File: rtl/board_gen_lfsr16.sv
// Free-running 16-bit Galois LFSR; also reused by game_logic for tie-breaks.
// Latency: new value every cycle, q reflects the register directly.
// Backpressure: none; advances unconditionally whenever out of reset.
module lfsr16
  import board_gen_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1  // must be nonzero or the LFSR locks up
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next value is always one Galois step ahead.
  always_comb begin
    lfsr_d = lfsr_step(lfsr_q);
  end

  // State register; reset reloads the seed so builds are reproducible.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q = lfsr_q;

endmodule

// File: rtl/board_gen.sv
// Builds a shuffled board of matching pairs (fill, Fisher-Yates shuffle, then hold).
// Latency: busy one cycle after start; done >= 2N cycles after start (N+1 with BOARD_GEN_NOSHUFFLE_EN).
// Backpressure: none; start while busy is ignored, done holds the board until the next start.
// BOARD_GEN_NOSHUFFLE_EN: when defined, skip the shuffle for a deterministic bring-up board.
module board_gen
  import board_gen_pkg::*;
#(
  parameter int          BITS = BITS_PER_BLOCK,
  parameter int          COLS = BLOCKS_WIDE,
  parameter int          ROWS = BLOCKS_HIGH,
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  board_gen_if.master bus
);

  localparam int N       = COLS * ROWS;
  localparam int IDX_W   = $clog2(N);
  localparam int BOARD_W = BITS * N;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] ONE_IDX  = IDX_W'(1);

  // State encodings stay local to this block.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_SHUF = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;          // fill index, then shuffle index i
  logic [BOARD_W-1:0] board_q, board_d;
  logic [15:0]        lfsr_w;

  // The LFSR runs in every state so the cycle at which start arrives is the entropy.
  lfsr16 #(
    .SEED (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_w)
  );

`ifdef BOARD_GEN_NOSHUFFLE_EN
  // Shuffle is compiled out; the LFSR keeps running only for game_logic's sake.
  logic lfsr_unused;
  assign lfsr_unused = ^lfsr_w;
`else
  logic             lfsr_unused;
  logic [IDX_W-1:0] draw_mask;
  logic [IDX_W-1:0] draw_r;
  logic [BITS-1:0]  sym_i;
  logic [BITS-1:0]  sym_r;

  assign lfsr_unused = ^lfsr_w[15:IDX_W];

  // Smallest all-ones mask covering v: smear the top set bit down to bit 0.
  function automatic logic [IDX_W-1:0] fill_mask(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] m;
    m = v;
    for (int s = 0; s < IDX_W; s++) begin
      m = m | (m >> 1);
    end
    return m;
  endfunction

  // Draw a candidate swap partner; values above i are rejected and redrawn next cycle,
  // which keeps the shuffle unbiased at the cost of a variable build time.
  always_comb begin
    draw_mask = fill_mask(k_q);
    draw_r    = lfsr_w[IDX_W-1:0] & draw_mask;
    sym_i     = board_q[k_q * BITS +: BITS];
    sym_r     = board_q[draw_r * BITS +: BITS];
  end
`endif

  // Next-state logic: one block written per FILL cycle, at most one swap per SHUFFLE cycle.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    board_d = board_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_FILL;
          k_d     = '0;
        end
      end

      S_FILL: begin
        // Blocks 2j and 2j+1 both get symbol j+1.
        board_d[k_q * BITS +: BITS] = BITS'(k_q >> 1) + BITS'(1);
        if (k_q == LAST_IDX) begin
`ifdef BOARD_GEN_NOSHUFFLE_EN
          state_d = S_DONE;
`else
          state_d = S_SHUF;
          k_d     = LAST_IDX;
`endif
        end else begin
          k_d = k_q + ONE_IDX;
        end
      end

      S_SHUF: begin
`ifndef BOARD_GEN_NOSHUFFLE_EN
        if (draw_r <= k_q) begin
          // r == i writes the same symbol back, which is the legal no-op swap.
          board_d[k_q * BITS +: BITS]    = sym_r;
          board_d[draw_r * BITS +: BITS] = sym_i;
          if (k_q == ONE_IDX) begin
            state_d = S_DONE;
          end else begin
            k_d = k_q - ONE_IDX;
          end
        end
`else
        state_d = S_DONE;
`endif
      end

      S_DONE: begin
        // Board is frozen here; a new start rebuilds from scratch.
        if (bus.start) begin
          state_d = S_FILL;
          k_d     = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any build and clears the board on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      board_q <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      board_q <= board_d;
    end
  end

  // Status decoded straight from the state register so they never glitch against board.
  always_comb begin
    bus.board = board_q;
    bus.busy  = (state_q == S_FILL) || (state_q == S_SHUF);
    bus.done  = (state_q == S_DONE);
  end

endmodule
